// File: rtl/avalon_mm_csr_master.sv
// Avalon-MM CSR initiator: one command at a time in, one response per command out.
// Stalls on waitrequest, waits for readdatavalid on reads, and aborts with an error on timeout.
module avalon_mm_csr_master #(
   parameter int ADDR_WIDTH     = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255   // must be >= 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   // command port
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_address,
   input  logic [DATA_WIDTH-1:0] cmd_writedata,
   // response port
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic                  rsp_error,
   output logic [DATA_WIDTH-1:0] rsp_readdata,
   // Avalon-MM initiator
   output logic [ADDR_WIDTH-1:0] csr_address,
   output logic                  csr_read,
   output logic                  csr_write,
   output logic [DATA_WIDTH-1:0] csr_writedata,
   input  logic                  csr_waitrequest,
   input  logic [DATA_WIDTH-1:0] csr_readdata,
   input  logic                  csr_readdatavalid,
   // status
   output logic [15:0]           timeout_count
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REQ    = 2'd1;
   localparam logic [1:0] S_RDWAIT = 2'd2;
   localparam logic [1:0] S_RSP    = 2'd3;

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]            r_state;
   logic [CNT_W-1:0]      r_wait_cnt;
   logic                  r_is_write;
   logic                  r_csr_read;
   logic                  r_csr_write;
   logic [ADDR_WIDTH-1:0] r_csr_address;
   logic [DATA_WIDTH-1:0] r_csr_writedata;
   logic                  r_rsp_valid;
   logic                  r_rsp_write;
   logic                  r_rsp_error;
   logic [DATA_WIDTH-1:0] r_rsp_readdata;
   logic [15:0]           r_timeout_count;

   logic w_cmd_fire;
   logic w_waiting;
   logic w_exit;
   logic w_abort;

   // cmd_ready is gated by reset_n so it is low for the whole reset window.
   assign cmd_ready  = (r_state == S_IDLE) & reset_n;
   assign w_cmd_fire = cmd_valid & cmd_ready;

   // A slave exit on the same edge as the timeout takes priority over the abort.
   assign w_waiting = (r_state == S_REQ) | (r_state == S_RDWAIT);
   assign w_exit    = ((r_state == S_REQ)    & ~csr_waitrequest) |
                      ((r_state == S_RDWAIT) &  csr_readdatavalid);
   assign w_abort   = w_waiting & ~w_exit & (r_wait_cnt == CNT_LAST);

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= S_IDLE;
         r_wait_cnt      <= '0;
         r_is_write      <= 1'b0;
         r_csr_read      <= 1'b0;
         r_csr_write     <= 1'b0;
         r_csr_address   <= '0;
         r_csr_writedata <= '0;
         r_rsp_valid     <= 1'b0;
         r_rsp_write     <= 1'b0;
         r_rsp_error     <= 1'b0;
         r_rsp_readdata  <= '0;
         r_timeout_count <= '0;
      end else if (w_abort) begin
         r_csr_read     <= 1'b0;
         r_csr_write    <= 1'b0;
         r_rsp_valid    <= 1'b1;
         r_rsp_write    <= r_is_write;
         r_rsp_error    <= 1'b1;
         r_rsp_readdata <= '0;
         r_state        <= S_RSP;
         if (r_timeout_count != 16'hFFFF)
            r_timeout_count <= r_timeout_count + 16'd1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_cmd_fire) begin
                  r_is_write      <= cmd_write;
                  r_csr_read      <= ~cmd_write;
                  r_csr_write     <= cmd_write;
                  r_csr_address   <= cmd_address;
                  r_csr_writedata <= cmd_writedata;
                  r_wait_cnt      <= '0;
                  r_state         <= S_REQ;
               end
            end
            S_REQ: begin
               if (!csr_waitrequest) begin
                  r_csr_read  <= 1'b0;
                  r_csr_write <= 1'b0;
                  r_wait_cnt  <= '0;
                  if (r_is_write) begin
                     r_rsp_valid    <= 1'b1;
                     r_rsp_write    <= 1'b1;
                     r_rsp_error    <= 1'b0;
                     r_rsp_readdata <= '0;
                     r_state        <= S_RSP;
                  end else begin
                     r_state <= S_RDWAIT;
                  end
               end else begin
                  r_wait_cnt <= r_wait_cnt + CNT_W'(1);
               end
            end
            S_RDWAIT: begin
               if (csr_readdatavalid) begin
                  r_rsp_valid    <= 1'b1;
                  r_rsp_write    <= 1'b0;
                  r_rsp_error    <= 1'b0;
                  r_rsp_readdata <= csr_readdata;
                  r_state        <= S_RSP;
               end else begin
                  r_wait_cnt <= r_wait_cnt + CNT_W'(1);
               end
            end
            S_RSP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign csr_address   = r_csr_address;
   assign csr_read      = r_csr_read;
   assign csr_write     = r_csr_write;
   assign csr_writedata = r_csr_writedata;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_write     = r_rsp_write;
   assign rsp_error     = r_rsp_error;
   assign rsp_readdata  = r_rsp_readdata;
   assign timeout_count = r_timeout_count;

endmodule

// File: tb/tb_avalon_mm_csr_master.sv
// Directed bench for avalon_mm_csr_master: write, read, stall, timeout, backpressure, reset-in-REQ.
// Inputs are driven and outputs sampled on the falling edge, away from the active rising edge.
module tb_avalon_mm_csr_master;

   localparam int AW = 2;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_address;
   logic [DW-1:0] cmd_writedata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_write;
   logic          rsp_error;
   logic [DW-1:0] rsp_readdata;
   logic [AW-1:0] csr_address;
   logic          csr_read;
   logic          csr_write;
   logic [DW-1:0] csr_writedata;
   logic          csr_waitrequest;
   logic [DW-1:0] csr_readdata;
   logic          csr_readdatavalid;
   logic [15:0]   timeout_count;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   avalon_mm_csr_master #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_error(rsp_error), .rsp_readdata(rsp_readdata),
      .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
      .csr_writedata(csr_writedata), .csr_waitrequest(csr_waitrequest),
      .csr_readdata(csr_readdata), .csr_readdatavalid(csr_readdatavalid),
      .timeout_count(timeout_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic nedge();
      @(negedge clk);
   endtask

   task automatic drive_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_valid     = 1'b1;
      cmd_write     = wr;
      cmd_address   = a;
      cmd_writedata = d;
   endtask

   int cnt;
   logic [2:0] snap;

   initial begin
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
      cmd_writedata = '0; rsp_ready = 1'b1; csr_waitrequest = 1'b0;
      csr_readdata = '0; csr_readdatavalid = 1'b0;

      // reset state
      nedge();
      check("rst_cmd_ready", 32'(cmd_ready), 0);
      check("rst_csr_rw", {30'd0, csr_read, csr_write}, 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_tocnt", 32'(timeout_count), 0);
      nedge();
      reset_n = 1'b1;
      nedge();
      check("idle_cmd_ready", 32'(cmd_ready), 1);

      // write addr 0 data 1, no wait: rsp_valid after accept edge + REQ edge
      drive_cmd(1'b1, 2'd0, 32'h1);
      nedge();
      cmd_valid = 1'b0;
      check("wr_csr_write", 32'(csr_write), 1);
      check("wr_csr_read", 32'(csr_read), 0);
      check("wr_addr", 32'(csr_address), 0);
      check("wr_data", csr_writedata, 32'h1);
      check("wr_rsp_early", 32'(rsp_valid), 0);
      check("wr_busy", 32'(cmd_ready), 0);
      nedge();
      check("wr_csr_write_1cyc", 32'(csr_write), 0);
      check("wr_rsp_valid", 32'(rsp_valid), 1);
      check("wr_rsp_write", 32'(rsp_write), 1);
      check("wr_rsp_error", 32'(rsp_error), 0);
      check("wr_rsp_data", rsp_readdata, 0);
      nedge();
      check("wr_rsp_drop", 32'(rsp_valid), 0);
      check("wr_idle", 32'(cmd_ready), 1);

      // read addr 1, slave returns 5 one cycle after acceptance
      drive_cmd(1'b0, 2'd1, 32'hFFFF_FFFF);
      nedge();
      cmd_valid = 1'b0;
      check("rd_csr_read", 32'(csr_read), 1);
      check("rd_addr", 32'(csr_address), 1);
      nedge();
      check("rd_csr_read_1cyc", 32'(csr_read), 0);
      check("rd_rsp_early", 32'(rsp_valid), 0);
      csr_readdatavalid = 1'b1; csr_readdata = 32'h5;
      nedge();
      csr_readdatavalid = 1'b0; csr_readdata = '0;
      check("rd_rsp_valid", 32'(rsp_valid), 1);
      check("rd_rsp_data", rsp_readdata, 32'h5);
      check("rd_rsp_error", 32'(rsp_error), 0);
      check("rd_rsp_write", 32'(rsp_write), 0);
      nedge();
      check("rd_rsp_drop", 32'(rsp_valid), 0);

      // stall: waitrequest high for 10 REQ edges -> csr_read held 11 cycles
      csr_waitrequest = 1'b1;
      drive_cmd(1'b0, 2'd2, 32'h0);
      cnt = 0;
      for (int i = 1; i <= 11; i++) begin
         nedge();
         cmd_valid = 1'b0;
         if (csr_read && csr_address == 2'd2 && !rsp_valid) cnt++;
         if (i == 11) csr_waitrequest = 1'b0;
      end
      check("stall_hold_cycles", 32'(cnt), 11);
      nedge();
      check("stall_read_drop", 32'(csr_read), 0);
      csr_readdatavalid = 1'b1; csr_readdata = 32'hA5A5_0003;
      nedge();
      csr_readdatavalid = 1'b0; csr_readdata = '0;
      check("stall_rsp_valid", 32'(rsp_valid), 1);
      check("stall_rsp_data", rsp_readdata, 32'hA5A5_0003);
      check("stall_rsp_error", 32'(rsp_error), 0);
      check("stall_tocnt", 32'(timeout_count), 0);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         nedge();
         if (rsp_valid) cnt++;
      end
      check("stall_single_rsp", 32'(cnt), 0);

      // timeout: waitrequest stuck high -> csr_read for 16 cycles, then error response
      csr_waitrequest = 1'b1;
      rsp_ready = 1'b0;
      drive_cmd(1'b0, 2'd3, 32'h0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         nedge();
         cmd_valid = 1'b0;
         if (rsp_valid) break;
         if (csr_read) cnt++;
      end
      check("to_read_cycles", 32'(cnt), TO);
      check("to_rsp_valid", 32'(rsp_valid), 1);
      check("to_read_drop", 32'(csr_read), 0);
      check("to_rsp_error", 32'(rsp_error), 1);
      check("to_rsp_data", rsp_readdata, 0);
      check("to_tocnt", 32'(timeout_count), 1);
      csr_waitrequest = 1'b0;
      rsp_ready = 1'b1;
      nedge();
      check("to_rsp_drop", 32'(rsp_valid), 0);
      drive_cmd(1'b1, 2'd3, 32'hDEAD_BEEF);
      nedge();
      cmd_valid = 1'b0;
      check("to_next_write", 32'(csr_write), 1);
      check("to_next_wdata", csr_writedata, 32'hDEAD_BEEF);
      nedge();
      check("to_next_rsp", {29'd0, rsp_valid, rsp_write, rsp_error}, 3'b110);
      check("to_next_tocnt", 32'(timeout_count), 1);
      nedge();

      // backpressure: rsp_ready low for 5 cycles while the next command waits
      rsp_ready = 1'b0;
      drive_cmd(1'b1, 2'd2, 32'h1234_5678);
      nedge();
      cmd_valid = 1'b0;
      nedge();
      check("bp_rsp_valid", 32'(rsp_valid), 1);
      snap = {rsp_valid, rsp_write, rsp_error};
      drive_cmd(1'b0, 2'd1, 32'h0);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) nedge();
         if ({rsp_valid, rsp_write, rsp_error} == snap && rsp_readdata == 0 &&
             !cmd_ready && !csr_read && !csr_write) cnt++;
      end
      check("bp_stable_cycles", 32'(cnt), 5);
      rsp_ready = 1'b1;
      nedge();
      check("bp_rsp_drop", 32'(rsp_valid), 0);
      check("bp_cmd_ready", 32'(cmd_ready), 1);
      check("bp_not_yet", 32'(csr_read), 0);
      nedge();
      cmd_valid = 1'b0;
      check("bp_accept_read", 32'(csr_read), 1);
      check("bp_accept_addr", 32'(csr_address), 1);
      nedge();
      csr_readdatavalid = 1'b1; csr_readdata = 32'h77;
      nedge();
      csr_readdatavalid = 1'b0; csr_readdata = '0;
      check("bp_rd_rsp", {31'd0, rsp_valid}, 1);
      check("bp_rd_data", rsp_readdata, 32'h77);
      nedge();

      // reset during a stalled read
      csr_waitrequest = 1'b1;
      drive_cmd(1'b0, 2'd0, 32'h0);
      nedge();
      cmd_valid = 1'b0;
      nedge();
      check("rr_read_before", 32'(csr_read), 1);
      #2 reset_n = 1'b0;
      #1;
      check("rr_read_async", 32'(csr_read), 0);
      check("rr_cmd_ready", 32'(cmd_ready), 0);
      check("rr_tocnt", 32'(timeout_count), 0);
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         nedge();
         if (rsp_valid) cnt++;
      end
      reset_n = 1'b1;
      csr_waitrequest = 1'b0;
      nedge();
      check("rr_ready_after", 32'(cmd_ready), 1);
      csr_readdatavalid = 1'b1; csr_readdata = 32'hBAD0_BAD0;
      nedge();
      csr_readdatavalid = 1'b0; csr_readdata = '0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid || csr_read) cnt++;
         nedge();
      end
      check("rr_no_rsp", 32'(cnt), 0);
      check("rr_still_idle", 32'(cmd_ready), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
